// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC/LFSR engine: the controller state
// enumeration, default generator constants and a counter-width helper.
// Constants are held 32 bits wide so that any legal WIDTH (4..32) can take
// them with a size cast (zero-extension or truncation to WIDTH bits).
// ---------------------------------------------------------------------------
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } crc_state_e;

   localparam int          CRC_WIDTH_DEF = 8;
   localparam logic [31:0] CRC_SEED_DEF  = 32'h0000_00D8;
   localparam logic [31:0] CRC_POLY_DEF  = 32'h0000_0044;

   // Bits needed to count 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// ---------------------------------------------------------------------------
// crc_lfsr_step
// Combinational single-bit Galois LFSR update.
//   fb          = DATA ^ STATE[0]
//   NEXT[W-1]   = fb
//   NEXT[i]     = STATE[i+1] ^ (POLY[i] & fb)    for i < W-1
// POLY[WIDTH-1] has no tap position and is ignored.
//
// Ports
//   STATE  in  WIDTH  current register value
//   DATA   in  1      message bit being folded in
//   NEXT   out WIDTH  register value after one step
// ---------------------------------------------------------------------------
module crc_lfsr_step
   import crc_pkg::*;
#(
   parameter int               WIDTH = CRC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(CRC_POLY_DEF)
) (
   input  logic [WIDTH-1:0] STATE,
   input  logic             DATA,
   output logic [WIDTH-1:0] NEXT
);

   logic fb;

   always_comb begin
      fb          = DATA ^ STATE[0];
      NEXT        = '0;
      NEXT[WIDTH-1] = fb;
      for (int i = 0; i < WIDTH - 1; i++) begin
         NEXT[i] = STATE[i+1] ^ (POLY[i] & fb);
      end
   end

endmodule

// File: rtl/crc_lfsr_engine.sv
// ---------------------------------------------------------------------------
// crc_lfsr_engine
// Serial CRC engine: accepts a message one bit at a time, folds each bit into
// a Galois LFSR, then streams the final register (XOR_OUT applied) out LSB
// first under ready/valid handshake, and pulses DONE after the last bit.
//
// Ports
//   CLK         in   1  clock, all state on rising edge
//   RST         in   1  synchronous active-high reset, overrides everything
//   START       in   1  abort any run, reload SEED, enter SHIFT
//   DATA        in   1  serial message bit
//   DATA_VALID  in   1  DATA qualifier (only honoured in SHIFT)
//   LAST        in   1  final message bit marker, sampled with DATA_VALID
//   IN_READY    out  1  high in SHIFT
//   CRC         out  1  serial CRC bit (register LSB) during DRAIN, else 0
//   CRC_VALID   out  1  high in DRAIN
//   CRC_READY   in   1  downstream accepts CRC bit
//   BUSY        out  1  high in SHIFT or DRAIN
//   DONE        out  1  one-cycle pulse after the final CRC bit transfer
// ---------------------------------------------------------------------------
module crc_lfsr_engine
   import crc_pkg::*;
#(
   parameter int               WIDTH   = CRC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(CRC_SEED_DEF),
   parameter logic [WIDTH-1:0] POLY    = WIDTH'(CRC_POLY_DEF),
   parameter logic [WIDTH-1:0] XOR_OUT = '0
) (
   input  logic CLK,
   input  logic RST,
   input  logic START,
   input  logic DATA,
   input  logic DATA_VALID,
   input  logic LAST,
   output logic IN_READY,
   output logic CRC,
   output logic CRC_VALID,
   input  logic CRC_READY,
   output logic BUSY,
   output logic DONE
);

   localparam int CNT_W = cnt_width(WIDTH);

   crc_state_e       state;
   crc_state_e       state_nxt;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] step_nxt;
   logic [CNT_W-1:0] bit_cnt;
   logic             accept;
   logic             xfer;
   logic             last_xfer;

   assign accept    = DATA_VALID & (state == ST_SHIFT);
   assign xfer      = CRC_READY & (state == ST_DRAIN);
   assign last_xfer = xfer & (bit_cnt == CNT_W'(WIDTH - 1));

   crc_lfsr_step #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_step (
      .STATE (lfsr),
      .DATA  (DATA),
      .NEXT  (step_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // START wins over every other transition, including a simultaneous
   // accepted bit, so an abort never leaks a partially folded message.
   always_comb begin
      state_nxt = state;
      if (START) begin
         state_nxt = ST_SHIFT;
      end else begin
         unique case (state)
            ST_IDLE:  state_nxt = ST_IDLE;
            ST_SHIFT: if (accept && LAST) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_xfer)      state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // The LAST bit is folded in and the output mask applied in the same edge,
   // so the register already holds the finished CRC when DRAIN begins.
   always_ff @(posedge CLK) begin
      if (RST || START) begin
         lfsr    <= SEED;
         bit_cnt <= '0;
      end else if (accept) begin
         lfsr    <= LAST ? (step_nxt ^ XOR_OUT) : step_nxt;
         bit_cnt <= '0;
      end else if (xfer) begin
         lfsr    <= lfsr >> 1;
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   assign IN_READY  = (state == ST_SHIFT);
   assign CRC_VALID = (state == ST_DRAIN);
   assign CRC       = (state == ST_DRAIN) & lfsr[0];
   assign BUSY      = (state == ST_SHIFT) | (state == ST_DRAIN);
   assign DONE      = (state == ST_DONE);

endmodule

// File: tb/tb_crc_lfsr_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_lfsr_engine
// Two engines side by side: index 0 uses the default generator (POLY 0x44),
// index 1 uses POLY 0 (pure rotate).  Each has its own stimulus and its own
// behavioural model; every cycle all outputs are compared with the model.
// Directed scenarios add literal expectations on the CRC streams.
// ---------------------------------------------------------------------------
module tb_crc_lfsr_engine;

   localparam logic [7:0] SEED_M    = 8'hD8;
   localparam logic [7:0] XOR_OUT_M = 8'h00;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst, start, data, dv, last, rdy;
   logic [1:0] in_ready, crc, crc_valid, busy, done;

   crc_lfsr_engine u_a (
      .CLK(clk), .RST(rst[0]), .START(start[0]), .DATA(data[0]),
      .DATA_VALID(dv[0]), .LAST(last[0]), .IN_READY(in_ready[0]),
      .CRC(crc[0]), .CRC_VALID(crc_valid[0]), .CRC_READY(rdy[0]),
      .BUSY(busy[0]), .DONE(done[0])
   );

   crc_lfsr_engine #(.POLY(8'h00)) u_b (
      .CLK(clk), .RST(rst[1]), .START(start[1]), .DATA(data[1]),
      .DATA_VALID(dv[1]), .LAST(last[1]), .IN_READY(in_ready[1]),
      .CRC(crc[1]), .CRC_VALID(crc_valid[1]), .CRC_READY(rdy[1]),
      .BUSY(busy[1]), .DONE(done[1])
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic armed = 1'b0;

   // Model: phase 0 idle, 1 taking message, 2 sending CRC, 3 finished.
   int         ph[2];
   logic [7:0] ms[2];
   int         mc[2];
   logic [7:0] mpoly[2];

   // Stream capture
   logic [31:0] strm[2];
   int          nbits[2];
   int          done_seen[2];
   int          done_cyc[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Polynomial division by one message bit: shift right, and if the bit
   // leaving (xor the incoming data) is 1, inject the feedback pattern.
   function automatic logic [7:0] mstep(input logic [7:0] s, input logic d, input logic [7:0] p);
      int v;
      int fb;
      v  = int'(s);
      fb = (v % 2) ^ int'(d);
      v  = v / 2;
      if (fb == 1) v = v ^ (32'h80 | int'(p & 8'h7F));
      return v[7:0];
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
               ph[k] = 0; ms[k] = SEED_M; mc[k] = 0;
            end else if (start[k]) begin
               ph[k] = 1; ms[k] = SEED_M; mc[k] = 0;
            end else begin
               case (ph[k])
                  1: if (dv[k]) begin
                        ms[k] = mstep(ms[k], data[k], mpoly[k]);
                        if (last[k]) begin
                           ms[k] = ms[k] ^ XOR_OUT_M;
                           ph[k] = 2;
                           mc[k] = 0;
                        end
                     end
                  2: if (rdy[k]) begin
                        ms[k] = ms[k] / 2;
                        mc[k] = mc[k] + 1;
                        if (mc[k] == 8) ph[k] = 3;
                     end
                  3: ph[k] = 0;
                  default: ;
               endcase
            end
         end
      end
   end

   // Per-cycle compare and stream capture, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (armed) begin
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("in_ready[%0d]", k),  in_ready[k],  ph[k] == 1);
               chk($sformatf("busy[%0d]", k),      busy[k],      ph[k] == 1 || ph[k] == 2);
               chk($sformatf("crc_valid[%0d]", k), crc_valid[k], ph[k] == 2);
               chk($sformatf("crc[%0d]", k),       crc[k],       (ph[k] == 2) ? ms[k][0] : 1'b0);
               chk($sformatf("done[%0d]", k),      done[k],      ph[k] == 3);
               if (crc_valid[k] === 1'b1 && rdy[k] && nbits[k] < 32) begin
                  strm[k][nbits[k]] = crc[k];
                  nbits[k]++;
               end
               if (done[k] === 1'b1) begin
                  done_seen[k]++;
                  done_cyc[k] = cyc;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr(input int k);
      strm[k] = '0; nbits[k] = 0; done_seen[k] = 0; done_cyc[k] = 0;
   endtask

   task automatic do_start(input int k);
      start[k] = 1'b1; tick(); start[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic d, input logic l);
      data[k] = d; dv[k] = 1'b1; last[k] = l;
      tick();
      dv[k] = 1'b0; last[k] = 1'b0; data[k] = 1'($urandom);
   endtask

   task automatic send_zeros8(input int k);
      for (int i = 0; i < 8; i++) send(k, 1'b0, i == 7);
   endtask

   // Returns in the cycle DONE is high; an expired budget counts as a failure.
   task automatic wait_done(input int k, input int budget);
      int n;
      n = 0;
      while (done[k] !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk($sformatf("done_reached[%0d]", k), done[k], 1'b1);
   endtask

   task automatic chk_all_zero(input int k, input string tag);
      chk({tag, "_in_ready"},  in_ready[k],  1'b0);
      chk({tag, "_crc"},       crc[k],       1'b0);
      chk({tag, "_crc_valid"}, crc_valid[k], 1'b0);
      chk({tag, "_busy"},      busy[k],      1'b0);
      chk({tag, "_done"},      done[k],      1'b0);
   endtask

   // Random drain with backpressure and an occasional abort via START.
   task automatic drain_random(input int k);
      bit finished;
      finished = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (done[k] === 1'b1) begin
            finished = 1'b1;
            break;
         end
         if ($urandom_range(0, 39) == 0) begin
            rdy[k] = 1'b1;
            do_start(k);
            return;
         end
         rdy[k] = ($urandom_range(0, 2) != 0);
         tick();
      end
      rdy[k] = 1'b1;
      chk($sformatf("rand_drain_done[%0d]", k), finished, 1'b1);
      tick();
   endtask

   int t0;
   int lat0;

   initial begin
      mpoly[0] = 8'h44;
      mpoly[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         ph[k] = 0; ms[k] = SEED_M; mc[k] = 0;
         clr(k);
      end
      rst = 2'b11; start = '0; data = '0; dv = '0; last = '0; rdy = 2'b11;
      tick();
      armed = 1'b1;
      start = 2'b11; dv = 2'b11; last = 2'b11;   // reset must dominate
      tick();
      start = '0; dv = '0; last = '0;
      chk_all_zero(0, "reset_a");
      chk_all_zero(1, "reset_b");
      rst = '0;
      tick();

      // Rotate-only engine: eight zero bits return the seed unchanged.
      clr(1);
      do_start(1);
      send_zeros8(1);
      chk("lat_crc_valid", crc_valid[1], 1'b1);
      chk("lat_in_ready",  in_ready[1],  1'b0);
      wait_done(1, 40);
      tick();
      chk("rot_stream", strm[1], 32'hD8);
      chk("rot_nbits",  nbits[1], 8);
      chk("rot_done1",  done_seen[1], 1);

      // Default engine: one data bit of 1 gives 0xA8.
      clr(0);
      do_start(0);
      send(0, 1'b1, 1'b1);
      t0 = cyc;
      chk("model_state_a8", ms[0], 8'hA8);
      wait_done(0, 40);
      tick();
      chk("one_bit_stream", strm[0], 32'hA8);
      chk("one_bit_nbits",  nbits[0], 8);
      lat0 = done_cyc[0] - t0;

      // Same with three stall cycles after two transfers.
      clr(0);
      do_start(0);
      send(0, 1'b1, 1'b1);
      t0 = cyc;
      tick(); tick();
      rdy[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", crc_valid[0], 1'b1);
         chk("stall_crc",   crc[0],       1'b0);
      end
      rdy[0] = 1'b1;
      wait_done(0, 40);
      tick();
      chk("stall_stream", strm[0], 32'hA8);
      chk("stall_delay",  done_cyc[0] - t0, lat0 + 3);

      // Abort in mid-drain, then rerun without another START.
      clr(1);
      do_start(1);
      send_zeros8(1);
      tick(); tick(); tick(); tick();
      do_start(1);
      chk("abort_valid",    crc_valid[1], 1'b0);
      chk("abort_in_ready", in_ready[1],  1'b1);
      tick(); tick(); tick();
      chk("abort_no_done", done_seen[1], 0);
      clr(1);
      send_zeros8(1);
      wait_done(1, 40);
      tick();
      chk("abort_rerun_stream", strm[1], 32'hD8);

      // Reset after three message bits.
      clr(0);
      do_start(0);
      for (int i = 0; i < 3; i++) send(0, 1'($urandom), 1'b0);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      chk_all_zero(0, "midrst");
      do_start(0);
      send(0, 1'b1, 1'b1);
      wait_done(0, 40);
      tick();
      chk("midrst_stream", strm[0], 32'hA8);

      // DATA_VALID in IDLE and in DONE is ignored.
      send(1, 1'b1, 1'b1);
      clr(1);
      do_start(1);
      send_zeros8(1);
      wait_done(1, 40);
      send(1, 1'b1, 1'b1);
      chk("ign_stream1", strm[1], 32'hD8);
      clr(1);
      do_start(1);
      send_zeros8(1);
      wait_done(1, 40);
      tick();
      chk("ign_stream2", strm[1], 32'hD8);
      chk("ign_done1",   done_seen[1], 1);

      // Randomised messages; the per-cycle model compare does the checking.
      for (int m = 0; m < 80; m++) begin
         int k;
         int len;
         k   = m % 2;
         len = $urandom_range(1, 16);
         do_start(k);
         for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 2) == 0) tick();
            send(k, 1'($urandom), i == len - 1);
         end
         drain_random(k);
         if ($urandom_range(0, 4) == 0) send(k, 1'($urandom), 1'b1);
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/crc_lfsr_engine.md
CRC_LFSR_ENGINE -- requirements
Module: crc_lfsr_engine

Interface
REQ-001 Parameter WIDTH, default 8: LFSR/CRC length in bits, legal range 4..32.
REQ-002 Parameter SEED, default 8'hD8 (zero-extended to WIDTH): value loaded at reset and at START.
REQ-003 Parameter POLY, default 8'h44 (WIDTH bits): bit i (0..WIDTH-2) set means feedback XORs into state bit i.
REQ-004 Parameter XOR_OUT, default 0 (WIDTH bits): mask XORed into the state on entry to DRAIN.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 START  in  1  one-cycle pulse; loads SEED and enters SHIFT.
REQ-008 DATA  in  1  serial message bit.
REQ-009 DATA_VALID  in  1  DATA qualifier.
REQ-010 LAST  in  1  marks the final message bit; sampled with DATA_VALID.
REQ-011 IN_READY  out  1  high only in SHIFT.
REQ-012 CRC  out  1  serial CRC bit, LSB first.
REQ-013 CRC_VALID  out  1  CRC qualifier.
REQ-014 CRC_READY  in  1  downstream accepts CRC when CRC_VALID and CRC_READY are both high.
REQ-015 BUSY  out  1  high in SHIFT or DRAIN.
REQ-016 DONE  out  1  one-cycle pulse after the last CRC bit transfers.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DRAIN, and DONE.
REQ-018 IDLE->SHIFT on START; SHIFT->DRAIN on an accepted bit with LAST=1; DRAIN->DONE on transfer of bit WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-019 Input acceptance SHALL be defined as DATA_VALID & IN_READY; the engine SHALL update the state exactly once per accepted bit, and a cycle with no acceptance SHALL hold the state.
REQ-020 Update on acceptance: fb = DATA ^ s[0]; s[WIDTH-1] <= fb; for i < WIDTH-1, s[i] <= s[i+1] ^ (POLY[i] & fb).
REQ-021 The accepted LAST bit SHALL itself be folded into the state, and the next state SHALL equal the updated value XOR XOR_OUT.
REQ-022 CRC_VALID SHALL be high throughout DRAIN, and CRC SHALL equal s[0].
REQ-023 On each DRAIN transfer, s SHALL shift right with zero fill and the bit counter (width clog2(WIDTH+1)) SHALL increment.
REQ-024 CRC and CRC_VALID SHALL hold stable while CRC_READY is low (backpressure); the counter SHALL not advance.
REQ-025 Latency: CRC_VALID SHALL rise the cycle after the LAST bit is accepted.
REQ-026 The counter SHALL reset to 0 on entry to DRAIN; the transfer at count WIDTH-1 ends DRAIN, with no wrap-around.
REQ-027 START in any state, including mid-SHIFT or mid-DRAIN, SHALL abort the operation, reload SEED, clear the counter, drop CRC_VALID, and enter SHIFT next cycle; DONE SHALL not pulse.
REQ-028 START in the same cycle as an accepted bit SHALL take priority, and that bit SHALL be discarded.
REQ-029 DATA_VALID outside SHIFT SHALL be ignored, and the state SHALL not change.
REQ-030 Outside DRAIN, CRC SHALL be driven 0.

Reset
REQ-031 With RST high at a clock edge, the engine SHALL load s=SEED, counter=0, and state=IDLE.
REQ-032 Under reset, IN_READY, CRC, CRC_VALID, BUSY, and DONE SHALL all be 0.
REQ-033 RST SHALL override START and all other inputs.
REQ-034 Reset mid-operation SHALL discard all progress.

Structure
REQ-035 The FSM state enumeration and the default WIDTH/SEED/POLY constants SHALL reside in shared package crc_pkg.
REQ-036 The next-state update (REQ-020) SHALL be a sub-module, crc_lfsr_step, that is combinational and parametrised on WIDTH/POLY.
REQ-037 The step sub-module SHALL be instantiated once.
REQ-038 The FSM, counter, and serializer SHALL reside in crc_lfsr_engine.

Verification
REQ-039 Defaults with POLY=0: START, then 8 bits of DATA=0 with LAST on the 8th -> CRC stream 0,0,0,1,1,0,1,1 (0xD8 LSB first), then DONE pulse.
REQ-040 Defaults: START, then a single bit DATA=1 with LAST=1 -> state 0xA8, CRC stream 0,0,0,1,0,1,0,1.
REQ-041 As REQ-040 but CRC_READY held low for 3 cycles after bit 2 -> CRC=0 held with CRC_VALID high, remaining bits unchanged, DONE delayed 3 cycles.
REQ-042 START asserted at DRAIN bit 4 -> CRC_VALID low next cycle, IN_READY high, no DONE pulse, and a rerun of REQ-039 produces an identical stream.
REQ-043 RST asserted mid-SHIFT after 3 bits -> all outputs 0 next cycle; START plus REQ-040 stimulus still yields 0xA8.
REQ-044 DATA_VALID pulsed in IDLE and DONE -> no state change, and the subsequent REQ-039 result is unchanged.
